// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: I/O map, status bits,
// default geometry of the receive buffer and the intake state encoding.
package uart_rx_fifo_pkg;

    // Default receive buffer geometry (byte wide, 16 entries)
    localparam int unsigned RX_DATA_W     = 32'd8;
    localparam int unsigned RX_DEPTH_LOG2 = 32'd4;

    // CPU I/O addresses of the UART register block
    localparam logic [15:0] UART_DATA   = 16'h1000;
    localparam logic [15:0] UART_STATUS = 16'h1004;
    localparam logic [15:0] UART_BAUD   = 16'h1008;

    // Bit positions inside the status word at UART_STATUS
    localparam int unsigned STAT_BUSY_BIT    = 32'd0;
    localparam int unsigned STAT_VALID_BIT   = 32'd1;
    localparam int unsigned STAT_DTR_BIT     = 32'd2;
    localparam int unsigned STAT_OVERRUN_BIT = 32'd3;

    // Intake FSM: take a byte, then two dead cycles while buart clears valid
    typedef enum logic [1:0] {
        RX_IDLE  = 2'b00,
        RX_ACK   = 2'b01,
        RX_GUARD = 2'b10
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle between the receive buffer and its neighbours: the buart holding
// register handshake on one side, the CPU read/status path on the other.
// The slave modport is the buffer itself; master is whoever drives it.
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DATA       = RX_DATA_W,
    parameter int unsigned DEPTH_LOG2 = RX_DEPTH_LOG2
);
    logic                  rx_valid;
    logic [DATA-1:0]       rx_data;
    logic                  rx_rd;
    logic                  pop;
    logic [DATA-1:0]       q;
    logic                  not_empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic                  overrun;
    logic                  clr_overrun;

    modport master (
        output rx_valid, rx_data, pop, clr_overrun,
        input  rx_rd, q, not_empty, full, count, overrun
    );

    modport slave (
        input  rx_valid, rx_data, pop, clr_overrun,
        output rx_rd, q, not_empty, full, count, overrun
    );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO. A push when full is
// only accepted if a pop frees a slot in the same cycle; a pop when empty
// is ignored. Occupancy is kept in its own counter so full and empty are
// unambiguous without an extra pointer bit.
module sync_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DATA       = RX_DATA_W,
    parameter int unsigned DEPTH_LOG2 = RX_DEPTH_LOG2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [DATA-1:0]     wdata,
    output logic [DATA-1:0]     rdata,
    output logic [DEPTH_LOG2:0] count,
    output logic                not_empty,
    output logic                full
);
    localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 32'd1;

    localparam logic [DEPTH_LOG2:0]   CNT_FULL = CW'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = CW'(1'b1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1'b1);

    logic [DATA-1:0]       mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_r;
    logic [DEPTH_LOG2-1:0] rptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  not_empty_s;
    logic                  full_s;
    logic                  pop_ok_s;
    logic                  push_ok_s;

    // Status flags and accepted push/pop, all derived from the occupancy count
    always_comb begin
        not_empty_s = (count_r != '0);
        full_s      = (count_r == CNT_FULL);
        pop_ok_s    = pop & not_empty_s;
        push_ok_s   = push & (~full_s | pop_ok_s);
    end

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally modulo depth
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata     = mem_r[rptr_r];
    assign count     = count_r;
    assign not_empty = not_empty_s;
    assign full      = full_s;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer between buart and the CPU read path. Each byte in
// buart's holding register is copied into the FIFO and acknowledged with a
// one-cycle rx_rd pulse; two dead cycles follow so the registered clear of
// buart's valid is seen before the next look. A byte arriving while full is
// still acknowledged (buart must never stall) but dropped, and the sticky
// overrun flag records the loss until firmware clears it.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DATA       = RX_DATA_W,
    parameter int unsigned DEPTH_LOG2 = RX_DEPTH_LOG2
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);
    rx_state_e             state_r;
    logic                  rx_rd_r;
    logic                  overrun_r;
    logic                  push_s;
    logic                  drop_s;
    logic [DATA-1:0]       q_s;
    logic [DEPTH_LOG2:0]   count_s;
    logic                  not_empty_s;
    logic                  full_s;

    // Push request and drop detection; when full, not_empty holds so pop is always honoured
    always_comb begin
        push_s = (state_r == RX_IDLE) & bus.rx_valid;
        drop_s = push_s & full_s & ~bus.pop;
    end

    sync_fifo #(
        .DATA       (DATA),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .pop       (bus.pop),
        .wdata     (bus.rx_data),
        .rdata     (q_s),
        .count     (count_s),
        .not_empty (not_empty_s),
        .full      (full_s)
    );

    // Intake FSM with registered one-cycle acknowledge to buart
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RX_IDLE;
            rx_rd_r <= 1'b0;
        end else begin
            case (state_r)
                RX_IDLE: begin
                    if (bus.rx_valid) begin
                        state_r <= RX_ACK;
                        rx_rd_r <= 1'b1;
                    end else begin
                        state_r <= RX_IDLE;
                        rx_rd_r <= 1'b0;
                    end
                end
                RX_ACK: begin
                    state_r <= RX_GUARD;
                    rx_rd_r <= 1'b0;
                end
                RX_GUARD: begin
                    state_r <= RX_IDLE;
                    rx_rd_r <= 1'b0;
                end
                default: begin
                    state_r <= RX_IDLE;
                    rx_rd_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun: a drop sets it and wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign bus.rx_rd     = rx_rd_r;
    assign bus.q         = q_s;
    assign bus.count     = count_s;
    assign bus.not_empty = not_empty_s;
    assign bus.full      = full_s;
    assign bus.overrun   = overrun_r;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer between the buart receiver and the CPU I/O read path.
- Drains each received byte out of buart's single holding register into a FIFO of 2**DEPTH_LOG2 bytes, acknowledging buart with a one-cycle rd pulse.
- Presents the head byte to the I/O read mux at 0x1000 and pops it on a CPU read strobe.
- Absorbs bursts at 921600 baud while firmware is busy; reports overrun when it overflows.

Parameters:
- DATA, 8, byte width.
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries).

Ports:
- clk  in  1  system clock (fclk domain).
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  buart valid: holding register contains a byte.
- rx_data  in  DATA  buart rx_data.
- rx_rd  out  1  one-cycle acknowledge to buart rd; buart clears valid.
- pop  in  1  CPU read strobe (registered io_rd & addr==0x1000).
- q  out  DATA  head byte, first-word-fall-through.
- not_empty  out  1  q is valid.
- full  out  1  count == 2**DEPTH_LOG2.
- count  out  DEPTH_LOG2+1  occupancy.
- overrun  out  1  sticky: a byte was dropped.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset (clk edge with reset=1): pointers=0, count=0, not_empty=0, full=0, overrun=0, rx_rd=0, FSM=IDLE. q is don't-care while empty; the bench drives 0 for it.
- Storage: array of 2**DEPTH_LOG2 x DATA. Write/read pointers are DEPTH_LOG2 bits and wrap modulo depth. count is separate, DEPTH_LOG2+1 bits.
- Intake FSM, 3 states:
  - IDLE: if rx_valid, capture rx_data into the FIFO per the push rules, assert rx_rd for exactly 1 cycle, go to ACK.
  - ACK: rx_rd=0 -> GUARD.
  - GUARD: rx_rd=0 -> IDLE.
  - The two dead cycles cover buart's registered clear of valid. One byte is therefore taken at most every 3 cycles, far above line rate.
- Push (IDLE & rx_valid):
  - Not full: write at wptr, wptr+1, count+1.
  - Full and pop in the same cycle: push accepted, count unchanged.
  - Full and no pop: byte dropped, still acknowledged (rx_rd=1) so buart never stalls, overrun<=1.
- Pop: if pop & not_empty, rptr+1, count-1. Pop while empty is ignored (no underflow, count stays 0).
- Simultaneous push and pop when not empty: both pointers advance, count unchanged, q updates to the next entry.
- Simultaneous push and pop when empty: pop ignored, push accepted, count=1.
- Timing of q: the head byte is visible on q the cycle after its push (registered array write, combinational read of mem[rptr]). not_empty and count update on the same edge as the write.
- not_empty = (count!=0); full = (count==depth); both derived from count, no extra state.
- Overrun flag:
  - Set on a drop, cleared by clr_overrun.
  - Set and clear in the same cycle: set wins.
  - Overrun is never cleared by pop.
- Reset mid-operation (including in ACK or GUARD): FIFO empties, FSM returns to IDLE, rx_rd=0 on the next cycle. A byte still held in buart is re-taken after reset deasserts.

Decomposition:
- Shared package holds:
  - I/O address constants: UART_DATA=16'h1000, UART_STATUS=16'h1004, UART_BAUD=16'h1008.
  - Status bit positions within the 0x1004 word: busy bit0, valid bit1, DTR bit2, overrun bit3.
- One natural sub-module: sync_fifo (generic DATA/DEPTH_LOG2 storage, pointers, count). uart_rx_fifo wraps it with the intake FSM and overrun logic.

Test Plan:
- Single byte: rx_valid=1, rx_data=8'h41 -> rx_rd high exactly 1 cycle; next cycle q=8'h41, not_empty=1, count=1. Then pop=1 -> count=0, not_empty=0.
- Fill/wrap: 20 pushes with 8'h00..8'h13, interleaved with 4 pops after the 10th push -> pops return 00..03. Final count=16, full=1, overrun=0. Remaining pops return 04..13 in order (pointer wrap exercised).
- Overrun: FIFO full, then byte 8'hEE arrives with no pop -> rx_rd pulses, count stays 16, overrun=1, head unchanged. clr_overrun -> overrun=0.
- Full push+pop same cycle: FIFO full with head 8'h00, push 8'h99 with pop -> count=16, overrun=0, 8'h99 is last out after 15 more pops.
- Empty pop plus simultaneous push: pop=1 on an empty FIFO -> count 0, no change. Push and pop on an empty FIFO in the same cycle -> count=1, q=pushed byte.
- Reset mid-ACK: assert reset the cycle after rx_rd -> next cycle count=0, not_empty=0, rx_rd=0, overrun=0. With rx_valid still high after reset drops, the byte is re-taken and count=1.
